// File: rtl/ama_riscv_store_align.sv
// Store alignment unit: turns one store request into one or two lane-aligned bus beats.
// Boundary-crossing stores are either split into two beats or rejected with a one-cycle error.
module ama_riscv_store_align #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_width,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_mask,
  output logic                misalign_err
);

  // state | meaning
  // IDLE  | no store pending, ready for a request
  // BEAT0 | low (or only) beat presented on the bus
  // BEAT1 | high beat of a split store presented on the bus
  // ERR   | request rejected, misalign_err pulsing for one cycle

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  state_t              state;
  logic                cross_q;
  logic [ADDR_W-1:0]   hi_addr_q;
  logic [DATA_W-1:0]   hi_wdata_q;
  logic [NB-1:0]       hi_mask_q;

  logic [1:0]          size;
  logic [OFF_W-1:0]    off;
  logic [2*NB-1:0]     base_mask;
  logic [2*NB-1:0]     full_mask;
  logic [DATA_W-1:0]   trunc_data;
  logic [2*DATA_W-1:0] full_data;
  logic [ADDR_W-1:0]   lo_addr_c;
  logic [ADDR_W-1:0]   hi_addr_c;
  logic                bad_size;
  logic                cross_c;
  logic                to_err;
  logic                last_beat;
  logic                accept;
  logic                unused_width;

  assign size         = req_width[1:0];
  assign unused_width = req_width[2];
  assign off          = req_addr[OFF_W-1:0];

  always_comb begin
    base_mask = '0;
    case (size)
      2'd0:    base_mask[0]   = 1'b1;
      2'd1:    base_mask[1:0] = 2'b11;
      2'd2:    base_mask[3:0] = 4'hF;
      default: base_mask[7:0] = 8'hFF;
    endcase
  end

  // Bytes beyond the access size are zeroed before shifting so unused lanes stay 0.
  always_comb begin
    trunc_data = '0;
    for (int i = 0; i < NB; i++) begin
      trunc_data[8*i +: 8] = base_mask[i] ? req_wdata[8*i +: 8] : 8'h00;
    end
  end

  assign full_mask = base_mask << off;
  assign full_data = {{DATA_W{1'b0}}, trunc_data} << {off, 3'b000};
  assign lo_addr_c = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hi_addr_c = lo_addr_c + ADDR_W'(NB);
  assign bad_size  = (size == 2'd3) && (DATA_W == 32);
  assign cross_c   = |full_mask[2*NB-1:NB];
  assign to_err    = bad_size || (cross_c && (SPLIT_EN == 0));

  assign last_beat = (state == BEAT1) || ((state == BEAT0) && !cross_q);
  assign req_ready = rst_n && ((state == IDLE) || (state == ERR) || (last_beat && bus_ready));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cross_q      <= 1'b0;
      hi_addr_q    <= '0;
      hi_wdata_q   <= '0;
      hi_mask_q    <= '0;
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_mask     <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (accept) begin
        // accept is only possible when the current beat (if any) completes now
        if (to_err) begin
          state        <= ERR;
          misalign_err <= 1'b1;
          cross_q      <= 1'b0;
          bus_valid    <= 1'b0;
          bus_addr     <= '0;
          bus_wdata    <= '0;
          bus_mask     <= '0;
        end else begin
          state      <= BEAT0;
          cross_q    <= cross_c;
          hi_addr_q  <= hi_addr_c;
          hi_wdata_q <= full_data[2*DATA_W-1:DATA_W];
          hi_mask_q  <= full_mask[2*NB-1:NB];
          bus_valid  <= 1'b1;
          bus_addr   <= lo_addr_c;
          bus_wdata  <= full_data[DATA_W-1:0];
          bus_mask   <= full_mask[NB-1:0];
        end
      end else begin
        case (state)
          BEAT0: begin
            if (bus_ready) begin
              if (cross_q) begin
                state     <= BEAT1;
                bus_addr  <= hi_addr_q;
                bus_wdata <= hi_wdata_q;
                bus_mask  <= hi_mask_q;
              end else begin
                state     <= IDLE;
                bus_valid <= 1'b0;
                bus_addr  <= '0;
                bus_wdata <= '0;
                bus_mask  <= '0;
              end
            end
          end
          BEAT1: begin
            if (bus_ready) begin
              state     <= IDLE;
              cross_q   <= 1'b0;
              bus_valid <= 1'b0;
              bus_addr  <= '0;
              bus_wdata <= '0;
              bus_mask  <= '0;
            end
          end
          ERR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
